// File: rtl/pc_defs.sv
// Shared definitions for the program counter unit: FSM encoding, instruction size
// and the default reset address.
package pc_defs;

  typedef enum logic [1:0] {
    Boot  = 2'd0,
    Run   = 2'd1,
    Redir = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when an address is not on an instruction boundary.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr % INSTR_BYTES) != 0;
  endfunction

endpackage

// File: rtl/program_counter_unit_if.sv
// Fetch-side bus of the program counter unit: adder return, redirect request,
// hazard/ready handshake and the registered fetch request.
interface program_counter_unit_if;

  logic [31:0] PCAddResult;
  logic        RedirectValid;
  logic [31:0] RedirectTarget;
  logic        Stall;
  logic        FetchReady;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic        MisalignFault;

  // master: the PC unit itself; slave: the core/memory environment around it.
  modport master (
    input  PCAddResult, RedirectValid, RedirectTarget, Stall, FetchReady,
    output PCResult, FetchValid, MisalignFault
  );

  modport slave (
    output PCAddResult, RedirectValid, RedirectTarget, Stall, FetchReady,
    input  PCResult, FetchValid, MisalignFault
  );

endinterface

// File: rtl/pc_redirect_buffer.sv
// Single-entry pending-redirect store: a valid bit and a 32-bit target.
// A write overwrites any older entry; write takes priority over clear.
module pc_redirect_buffer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr,
  input  logic [31:0] wr_target,
  input  logic        clr,
  output logic        valid,
  output logic [31:0] target
);

  logic        valid_q;
  logic [31:0] target_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0;
    end else if (wr) begin
      valid_q  <= 1'b1;
      target_q <= wr_target;
    end else if (clr) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/program_counter_unit.sv
// Program counter with boot/run/redirect sequencing and a pending-redirect slot.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets are forced aligned and flagged.
module program_counter_unit
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                   Clk,
  input logic                   Reset,
  program_counter_unit_if.master bus
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid, accept;
  logic        pend_wr, pend_clr, pend_valid;
  logic [31:0] pend_target;
  logic        load_en;
  logic [31:0] load_raw, load_addr;
  logic        load_bad;

  assign fetch_valid = (state_q == Run);
  assign accept      = fetch_valid & bus.FetchReady;

  // A live redirect always outranks the stored one.
  assign load_raw = bus.RedirectValid ? bus.RedirectTarget : pend_target;

`ifdef PC_ALIGN_CHECK_EN
  assign load_addr = {load_raw[31:2], 2'b00};
  assign load_bad  = misaligned(load_raw);
`else
  assign load_addr = load_raw;
  assign load_bad  = 1'b0;
`endif

  pc_redirect_buffer u_redirect_buffer (
    .Clk       (Clk),
    .Reset     (Reset),
    .wr        (pend_wr),
    .wr_target (bus.RedirectTarget),
    .clr       (pend_clr),
    .valid     (pend_valid),
    .target    (pend_target)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_wr  = 1'b0;
    pend_clr = 1'b0;
    load_en  = 1'b0;
    unique case (state_q)
      Boot: begin
        state_d = Run;
        pend_wr = bus.RedirectValid;
      end
      Run: begin
        if (accept) begin
          if (bus.RedirectValid || (!bus.Stall && pend_valid)) begin
            load_en  = 1'b1;
            pc_d     = load_addr;
            pend_clr = 1'b1;
            state_d  = Redir;
          end else if (!bus.Stall) begin
            pc_d = bus.PCAddResult;
          end
        end else begin
          pend_wr = bus.RedirectValid;
        end
      end
      Redir: begin
        if (bus.RedirectValid) begin
          load_en = 1'b1;
          pc_d    = load_addr;
        end else begin
          state_d = Run;
        end
      end
      default: state_d = Boot;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= Boot;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else if (load_en && load_bad) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.MisalignFault = fault_q;
`else
  assign bus.MisalignFault = 1'b0;
`endif

  assign bus.PCResult   = pc_q;
  assign bus.FetchValid = fetch_valid;

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: per-cycle stimulus with expected
// outputs queued on drive and compared one cycle later.
module tb_program_counter_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit Align = 1'b1;
`else
  localparam bit Align = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        fault;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic fault_exp = 1'b0;
  exp_t sb[$];

  program_counter_unit_if bus ();

  program_counter_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // External PC adder.
  assign bus.PCAddResult = bus.PCResult + 32'd4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the edge, then compare.
  task automatic cyc(input string tag, input logic rst, input logic rv, input logic [31:0] rt,
                     input logic st, input logic fr, input logic [31:0] epc, input logic ev);
    exp_t e;
    Reset              = rst;
    bus.RedirectValid  = rv;
    bus.RedirectTarget = rt;
    bus.Stall          = st;
    bus.FetchReady     = fr;
    if (rst) fault_exp = 1'b0;
    sb.push_back('{tag, epc, ev, fault_exp});
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"}, bus.PCResult, e.pc);
      check({e.tag, ".valid"}, {31'd0, bus.FetchValid}, {31'd0, e.valid});
      check({e.tag, ".fault"}, {31'd0, bus.MisalignFault}, {31'd0, e.fault});
    end
  endtask

  logic [31:0] mis_pc;

  initial begin
    mis_pc = Align ? 32'h100 : 32'h102;

    // Reset then boot sequence.
    cyc("rst0",  1, 0, 0, 0, 1, 32'h0, 0);
    cyc("rst1",  1, 0, 0, 0, 1, 32'h0, 0);
    cyc("boot",  0, 0, 0, 0, 1, 32'h0, 1);
    cyc("seq4",  0, 0, 0, 0, 1, 32'h4, 1);
    cyc("seq8",  0, 0, 0, 0, 1, 32'h8, 1);
    // Stall holds the fetch address.
    cyc("stl1",  0, 0, 0, 1, 1, 32'h8, 1);
    cyc("stl2",  0, 0, 0, 1, 1, 32'h8, 1);
    cyc("stlx",  0, 0, 0, 0, 1, 32'hC, 1);
    // Redirect while not ready is buffered.
    cyc("nrdy0", 0, 1, 32'h100, 0, 0, 32'hC, 1);
    cyc("nrdy1", 0, 0, 0, 0, 0, 32'hC, 1);
    cyc("pend",  0, 0, 0, 0, 1, 32'h100, 0);
    cyc("pend1", 0, 0, 0, 0, 1, 32'h100, 1);
    cyc("pend2", 0, 0, 0, 0, 1, 32'h104, 1);
    // Newest pending redirect wins.
    cyc("nw0",   0, 1, 32'h200, 0, 0, 32'h104, 1);
    cyc("nw1",   0, 1, 32'h300, 0, 0, 32'h104, 1);
    cyc("nw2",   0, 0, 0, 0, 1, 32'h300, 0);
    cyc("nw3",   0, 0, 0, 0, 1, 32'h300, 1);
    cyc("nw4",   0, 0, 0, 0, 1, 32'h304, 1);
    // Redirect beats stall.
    cyc("rvst0", 0, 1, 32'h500, 1, 1, 32'h500, 0);
    cyc("rvst1", 0, 0, 0, 0, 1, 32'h500, 1);
    cyc("rvst2", 0, 0, 0, 0, 1, 32'h504, 1);
    // Redirect during REDIR reloads and extends it.
    cyc("ext0",  0, 1, 32'h600, 0, 1, 32'h600, 0);
    cyc("ext1",  0, 1, 32'h700, 0, 1, 32'h700, 0);
    cyc("ext2",  0, 0, 0, 0, 1, 32'h700, 1);
    cyc("ext3",  0, 0, 0, 0, 1, 32'h704, 1);
    // 32-bit wrap.
    cyc("wrp0",  0, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 0);
    cyc("wrp1",  0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc("wrp2",  0, 0, 0, 0, 1, 32'h0, 1);
    cyc("wrp3",  0, 0, 0, 0, 1, 32'h4, 1);
    // Misaligned redirect target.
    fault_exp = Align;
    cyc("mis0",  0, 1, 32'h102, 0, 1, mis_pc, 0);
    cyc("mis1",  0, 0, 0, 0, 1, mis_pc, 1);
    cyc("mis2",  0, 0, 0, 0, 1, mis_pc + 32'd4, 1);
    // Reset discards a pending redirect and clears the fault.
    cyc("rp0",   0, 1, 32'h400, 0, 0, mis_pc + 32'd4, 1);
    cyc("rp1",   1, 0, 0, 0, 1, 32'h0, 0);
    cyc("rp2",   0, 0, 0, 0, 1, 32'h0, 1);
    cyc("rp3",   0, 0, 0, 0, 1, 32'h4, 1);
    // Reset in REDIR, with a redirect on the reset cycle, is discarded too.
    cyc("rr0",   0, 1, 32'h900, 0, 1, 32'h900, 0);
    cyc("rr1",   1, 1, 32'hA00, 0, 1, 32'h0, 0);
    cyc("rr2",   0, 0, 0, 0, 1, 32'h0, 1);
    cyc("rr3",   0, 0, 0, 0, 1, 32'h4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on Reset.
REQ-002 SHALL have port Clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port PCAddResult  input  32  sequential next address (PCResult + 4) returned by the external PC adder.
REQ-005 SHALL have port RedirectValid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-006 SHALL have port RedirectTarget  input  32  redirect address, qualified by RedirectValid.
REQ-007 SHALL have port Stall  input  1  hazard hold; the accepted fetch is replayed and PC does not advance.
REQ-008 SHALL have port FetchReady  input  1  instruction memory accepts the current fetch.
REQ-009 SHALL have port PCResult  output  32  current fetch address, registered.
REQ-010 SHALL have port FetchValid  output  1  PCResult is a valid fetch request, registered.
REQ-011 SHALL have port MisalignFault  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-012 SHALL implement FSM states BOOT, RUN, REDIR; FetchValid = 1 only in RUN.
REQ-013 SHALL define accept = FetchValid & FetchReady.
REQ-014 BOOT: SHALL move to RUN after exactly one cycle; PCResult held at RESET_PC.
REQ-015 RUN, accept & Stall: SHALL hold PCResult and stay RUN (same address re-issued).
REQ-016 RUN, accept & ~Stall: next PC priority = RedirectTarget (RedirectValid=1) > pending target > PCAddResult.
REQ-017 RUN: when a redirect or pending target is loaded, SHALL go to REDIR and clear the pending entry; else stay RUN.
REQ-018 RUN, ~accept: PCResult and FetchValid SHALL stay stable; RedirectValid SHALL write the pending entry, newest overwriting older.
REQ-019 REDIR: FetchValid=0 for one cycle, then RUN; RedirectValid in REDIR SHALL load PCResult directly and extend REDIR by one cycle.
REQ-020 PC arithmetic SHALL be full 32-bit; PCAddResult wrap 32'hFFFF_FFFC -> 0 SHALL be accepted without special casing.
REQ-021 Stall and RedirectValid with accept in the same cycle: redirect SHALL win, PC loads target, Stall ignored that cycle.

Reset
REQ-022 Reset SHALL override all inputs: PCResult=RESET_PC, FetchValid=0, state=BOOT, pending cleared, MisalignFault=0.
REQ-023 Reset asserted mid-REDIR or with pending redirect SHALL discard the redirect.

Configuration
REQ-024 Macro PC_ALIGN_CHECK_EN defined: a loaded redirect target with [1:0]!=0 SHALL set MisalignFault (sticky until Reset) and load the target with [1:0] forced to 00.
REQ-025 Macro PC_ALIGN_CHECK_EN undefined: MisalignFault SHALL be constant 0 and targets SHALL load unmodified.

Structure
REQ-026 Shared package pc_defs SHALL hold the FSM state encoding, INSTR_BYTES=4 and the default RESET_PC constant.
REQ-027 Pending-redirect storage SHALL be sub-module pc_redirect_buffer (valid bit + 32-bit target, write/clear/read).

Verification
REQ-028 Reset, RESET_PC=0, FetchReady=1 -> PCResult 0 for two cycles (BOOT, RUN), then 4, 8, 12 on consecutive cycles.
REQ-029 PCResult=8, Stall=1 for 2 cycles with FetchReady=1 -> PCResult stays 8, FetchValid=1; after release -> 12.
REQ-030 PCResult=12, FetchReady=0, RedirectValid pulse target 0x100 -> PCResult stays 12; FetchReady=1 -> 0x100, one FetchValid=0 cycle, then 0x104.
REQ-031 FetchReady=0, two redirects 0x200 then 0x300 -> after accept PCResult=0x300 (newest wins).
REQ-032 With PC_ALIGN_CHECK_EN, redirect to 0x102 -> PCResult=0x100, MisalignFault=1 until Reset; without macro -> PCResult=0x102, MisalignFault=0.
REQ-033 Reset asserted in REDIR with pending 0x400 -> PCResult=RESET_PC, pending discarded, FetchValid=0, BOOT.
